// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register: 2-entry skid buffer between pipeline stages.
// The main slot drives out_data and the skid slot catches the one word that
// can arrive while the consumer stalls. in_ready is decoded from the state
// register only, so there is no combinational path from out_ready to in_ready.
// Optional feature: define PIPE_SKID_FLUSH_EN to get the flush port.
module pipeline_skid_register #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [WORD_LENGTH-1:0] out_data
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]             state;
  logic [WORD_LENGTH-1:0] main_data;
  logic [WORD_LENGTH-1:0] skid_data;
  logic                   in_fire;
  logic                   out_fire;
  logic                   flush_req;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state == BUSY) || (state == FULL);
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State and slot updates; reset beats flush, flush beats both handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush_req) begin
      // Contents are marked invalid but the data registers are left alone.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data <= in_data;
            state     <= FULL;
          end else if (out_fire) begin
            // out_data keeps its last value while invalid.
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid cannot fire.
          if (out_fire) begin
            main_data <= skid_data;
            state     <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// tb_pipeline_skid_register: directed vectors with hand-computed expectations
// for reset, single word, backpressure, drain order, streaming and flush.
module tb_pipeline_skid_register;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int failures;

  pipeline_skid_register #(.WORD_LENGTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and sampling happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = 1'b0;
`endif

    // 1. Reset held for two cycles with a word offered
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rel_out_data",  out_data,           32'd0);
    chk("rel_in_ready",  {31'b0, in_ready},  32'd1);

    // 2. Single word, consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0011;
    step();
    in_valid = 1'b0;
    chk("single_valid", {31'b0, out_valid}, 32'd1);
    chk("single_data",  out_data,           32'h11);
    step();
    chk("single_gone",  {31'b0, out_valid}, 32'd0);
    chk("single_keep",  out_data,           32'h11);

    // 3. Backpressure: two words fill the buffer, third is refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    step();
    chk("bp1_in_ready", {31'b0, in_ready},  32'd1);
    chk("bp1_data",     out_data,           32'hA1);
    in_data = 32'hA2;
    step();
    chk("bp2_in_ready", {31'b0, in_ready},  32'd0);
    chk("bp2_valid",    {31'b0, out_valid}, 32'd1);
    chk("bp2_data",     out_data,           32'hA1);
    in_data = 32'hA3;
    step();
    chk("bp3_in_ready", {31'b0, in_ready},  32'd0);
    chk("bp3_data",     out_data,           32'hA1);
    step();
    chk("bp4_data",     out_data,           32'hA1);

    // 4. Drain order with A3 still offered
    out_ready = 1'b1;
    chk("drain_a1", out_data, 32'hA1);
    step();
    chk("drain_a2",       out_data,          32'hA2);
    chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain_a3",       out_data,           32'hA3);
    chk("drain_a3_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("drain_empty",    {31'b0, out_valid}, 32'd0);

    // 5. Streaming 1..8 at one word per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      chk($sformatf("stream_data%0d", i), out_data, i);
      chk($sformatf("stream_vld%0d", i),  {31'b0, out_valid}, 32'd1);
      chk($sformatf("stream_rdy%0d", i),  {31'b0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_SKID_FLUSH_EN
    // 6. Flush from FULL together with an offered word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    step();
    in_data = 32'hB2;
    step();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush   = 1'b1;
    in_data = 32'hB3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid",    {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready},  32'd1);
    chk("fl_data",     out_data,           32'hB1);
    out_ready = 1'b1;
    step();
    chk("fl_no_emit", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hC1;
    step();
    in_valid = 1'b0;
    chk("fl_next_data",  out_data,           32'hC1);
    chk("fl_next_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("fl_next_gone",  {31'b0, out_valid}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
